// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the regfile_8x8 register file
//
// Purpose : operation codes, read-select codes and the default data width.
// Macro   : none (REGFILE_SAT_EN is consumed by reg_unit).

package regfile_pkg;

   localparam int REG_WIDTH = 8;

   // FunSel operation codes
   localparam logic [1:0] FUN_CLR = 2'b00;
   localparam logic [1:0] FUN_LD  = 2'b01;
   localparam logic [1:0] FUN_DEC = 2'b10;
   localparam logic [1:0] FUN_INC = 2'b11;

   // O1Sel/O2Sel codes; also the index of each register in the top-level array
   localparam logic [2:0] SEL_T1 = 3'd0;
   localparam logic [2:0] SEL_T2 = 3'd1;
   localparam logic [2:0] SEL_T3 = 3'd2;
   localparam logic [2:0] SEL_T4 = 3'd3;
   localparam logic [2:0] SEL_R1 = 3'd4;
   localparam logic [2:0] SEL_R2 = 3'd5;
   localparam logic [2:0] SEL_R3 = 3'd6;
   localparam logic [2:0] SEL_R4 = 3'd7;

endpackage

// File: rtl/regfile_8x8_if.sv
// rtl/regfile_8x8_if.sv - control/data bus of the regfile_8x8 register file
//
// Purpose : groups load data, operation/enable controls and both read ports.
// Signals : I (load data), FunSel (operation), RSel/TSel (enables),
//           O1Sel/O2Sel (read selects), O1/O2 (read data).
// Modports: master drives controls and reads data; slave is the register file.

interface regfile_8x8_if #(
   parameter int WIDTH = regfile_pkg::REG_WIDTH
);
   logic [WIDTH-1:0] I;
   logic [2:0]       O1Sel;
   logic [2:0]       O2Sel;
   logic [1:0]       FunSel;
   logic [3:0]       RSel;
   logic [3:0]       TSel;
   logic [WIDTH-1:0] O1;
   logic [WIDTH-1:0] O2;

   modport master (
      output I, O1Sel, O2Sel, FunSel, RSel, TSel,
      input  O1, O2
   );

   modport slave (
      input  I, O1Sel, O2Sel, FunSel, RSel, TSel,
      output O1, O2
   );
endinterface

// File: rtl/regfile_8x8_reg_unit.sv
// rtl/regfile_8x8_reg_unit.sv - one WIDTH-bit register with clear/load/dec/inc
//
// Purpose : single storage element of the register file.
// Macro   : REGFILE_SAT_EN - when defined, inc/dec saturate instead of wrapping.
// Ports   : clk, rst_n (async active-low), en_i (write enable),
//           fun_sel_i (operation), data_i (load data), q_o (current value).

module reg_unit
   import regfile_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [1:0]       fun_sel_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;
   logic [WIDTH-1:0] inc_val;
   logic [WIDTH-1:0] dec_val;

`ifdef REGFILE_SAT_EN
   // Stick at the rails rather than wrapping
   assign inc_val = (&value_q) ? value_q : value_q + WIDTH'(1);
   assign dec_val = (value_q == '0) ? value_q : value_q - WIDTH'(1);
`else
   assign inc_val = value_q + WIDTH'(1);
   assign dec_val = value_q - WIDTH'(1);
`endif

   always_comb begin
      value_d = value_q;
      if (en_i) begin
         case (fun_sel_i)
            FUN_CLR: value_d = '0;
            FUN_LD:  value_d = data_i;
            FUN_DEC: value_d = dec_val;
            FUN_INC: value_d = inc_val;
            default: value_d = value_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign q_o = value_q;

endmodule

// File: rtl/regfile_8x8.sv
// rtl/regfile_8x8.sv - eight-register file (R1..R4, T1..T4) with two read ports
//
// Purpose : maps RSel/TSel enable bits onto eight reg_unit instances and
//           provides two combinational 8:1 read muxes.
// Macro   : REGFILE_SAT_EN - saturating inc/dec (handled inside reg_unit).
// Ports   : clk, rst_n (async active-low), bus (regfile_8x8_if slave).

module regfile_8x8
   import regfile_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   regfile_8x8_if.slave   bus
);

   logic [7:0]       reg_en;
   logic [WIDTH-1:0] reg_val [8];

   // Array index equals the read-select code; enable bits are MSB-first
   // (bit3 = register 1), so each select nibble is reversed here.
   always_comb begin
      reg_en         = '0;
      reg_en[SEL_T1] = bus.TSel[3];
      reg_en[SEL_T2] = bus.TSel[2];
      reg_en[SEL_T3] = bus.TSel[1];
      reg_en[SEL_T4] = bus.TSel[0];
      reg_en[SEL_R1] = bus.RSel[3];
      reg_en[SEL_R2] = bus.RSel[2];
      reg_en[SEL_R3] = bus.RSel[1];
      reg_en[SEL_R4] = bus.RSel[0];
   end

   for (genvar k = 0; k < 8; k++) begin : g_reg
      reg_unit #(
         .WIDTH(WIDTH)
      ) u_reg (
         .clk       (clk),
         .rst_n     (rst_n),
         .en_i      (reg_en[k]),
         .fun_sel_i (bus.FunSel),
         .data_i    (bus.I),
         .q_o       (reg_val[k])
      );
   end

   assign bus.O1 = reg_val[bus.O1Sel];
   assign bus.O2 = reg_val[bus.O2Sel];

endmodule

// File: tb/tb_regfile_8x8.sv
// tb/tb_regfile_8x8.sv - scoreboard testbench for regfile_8x8

module tb_regfile_8x8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   regfile_8x8_if #(.WIDTH(8)) bus ();

   regfile_8x8 #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #50 clk = ~clk;

   typedef struct {
      logic [2:0] s1;
      logic [2:0] s2;
      logic [7:0] e1;
      logic [7:0] e2;
      string      nm;
   } exp_t;

   exp_t sb[$];
   event chk_ev;
   int   checks = 0;
   int   errors = 0;

`ifdef REGFILE_SAT_EN
   localparam logic [7:0] WRAP_INC = 8'hFF;
   localparam logic [7:0] WRAP_DEC = 8'h00;
`else
   localparam logic [7:0] WRAP_INC = 8'h00;
   localparam logic [7:0] WRAP_DEC = 8'hFF;
`endif

   // Monitor: samples both read ports 1ns after each request and pops the
   // matching expectation.
   initial begin
      exp_t e;
      forever begin
         @(chk_ev);
         #1;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: read with no expectation queued");
         end else begin
            e = sb.pop_front();
            checks++;
            if (bus.O1 !== e.e1) begin
               errors++;
               $display("FAIL %s O1 sel=%0d got=%h want=%h", e.nm, e.s1, bus.O1, e.e1);
            end
            checks++;
            if (bus.O2 !== e.e2) begin
               errors++;
               $display("FAIL %s O2 sel=%0d got=%h want=%h", e.nm, e.s2, bus.O2, e.e2);
            end
         end
      end
   end

   task automatic rd(input logic [2:0] s1, input logic [2:0] s2,
                     input logic [7:0] e1, input logic [7:0] e2, input string nm);
      exp_t e;
      bus.O1Sel = s1;
      bus.O2Sel = s2;
      e.s1 = s1; e.s2 = s2; e.e1 = e1; e.e2 = e2; e.nm = nm;
      sb.push_back(e);
      ->chk_ev;
      #2;
   endtask

   // Apply one operation on the next rising edge, then drop all enables.
   task automatic op(input logic [1:0] fun, input logic [3:0] rs,
                     input logic [3:0] ts, input logic [7:0] din);
      bus.FunSel = fun;
      bus.RSel   = rs;
      bus.TSel   = ts;
      bus.I      = din;
      @(posedge clk);
      #1;
      bus.RSel = 4'b0000;
      bus.TSel = 4'b0000;
   endtask

   task automatic sweep(input logic [7:0] v, input string nm);
      for (int k = 0; k < 4; k++) begin
         rd(3'(k), 3'(k + 4), v, v, nm);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.I      = 8'h00;
      bus.FunSel = 2'b00;
      bus.RSel   = 4'b0000;
      bus.TSel   = 4'b0000;
      bus.O1Sel  = 3'd0;
      bus.O2Sel  = 3'd0;

      // Async reset with no clock edge (first posedge is at t=50)
      #1 rst_n = 1'b0;
      #2;
      sweep(8'h00, "reset");
      for (int k = 0; k < 4; k++) rd(3'(7 - k), 3'(3 - k), 8'h00, 8'h00, "reset_rev");
      @(negedge clk);
      rst_n = 1'b1;

      // Load R2 and T4
      op(2'b01, 4'b0100, 4'b0001, 8'h18);
      rd(3'd5, 3'd3, 8'h18, 8'h18, "load_r2_t4");
      rd(3'd4, 3'd0, 8'h00, 8'h00, "load_r1_t1");
      rd(3'd6, 3'd7, 8'h00, 8'h00, "load_r3_r4");
      rd(3'd1, 3'd2, 8'h00, 8'h00, "load_t2_t3");

      // Hold with enables off
      op(2'b00, 4'b0000, 4'b0000, 8'h00);
      rd(3'd5, 3'd3, 8'h18, 8'h18, "hold");

      // Decrement then increment
      op(2'b10, 4'b0100, 4'b0001, 8'h00);
      rd(3'd5, 3'd3, 8'h17, 8'h17, "dec");
      op(2'b11, 4'b0100, 4'b0001, 8'h00);
      rd(3'd5, 3'd3, 8'h18, 8'h18, "inc");

      // Clear R2 only
      op(2'b00, 4'b0100, 4'b0000, 8'h00);
      rd(3'd5, 3'd3, 8'h00, 8'h18, "clear_hold");

      // Wrap / saturate
      op(2'b01, 4'b1000, 4'b0000, 8'hFF);
      rd(3'd4, 3'd4, 8'hFF, 8'hFF, "load_ff");
      op(2'b11, 4'b1000, 4'b0000, 8'h00);
      rd(3'd4, 3'd0, WRAP_INC, 8'h00, "inc_wrap");
      op(2'b10, 4'b0000, 4'b1000, 8'h00);
      rd(3'd0, 3'd4, WRAP_DEC, WRAP_INC, "dec_wrap");

      // Multi-enable load then async reset between edges
      op(2'b01, 4'b1111, 4'b1111, 8'hA5);
      sweep(8'hA5, "multi_load");
      rst_n = 1'b0;
      #1;
      rd(3'd0, 3'd7, 8'h00, 8'h00, "mid_reset_a");
      rd(3'd4, 3'd3, 8'h00, 8'h00, "mid_reset_b");
      rst_n = 1'b1;
      op(2'b01, 4'b0000, 4'b0000, 8'h3C);
      sweep(8'h00, "post_reset");

      #10;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
